// File: rtl/juice_dispense_ctrl_if.sv
// Vend command interface between the vending-decision FSM (master) and the
// dispense controller (slave). The requester holds vend_req/vend_sel until
// vend_ack; completion is reported through done/result.
interface juice_dispense_ctrl_if;
  logic       vend_req;
  logic [1:0] vend_sel;
  logic       vend_ack;
  logic       busy;
  logic       done;
  logic [1:0] result;

  modport master (
    output vend_req, vend_sel,
    input  vend_ack, busy, done, result
  );

  modport slave (
    input  vend_req, vend_sel,
    output vend_ack, busy, done, result
  );
endinterface

// File: rtl/juice_dispense_ctrl.sv
// Juice dispense controller: accepts vend commands, pulses the slot motors or
// the coin-return actuator, confirms drops through a synchronised product
// sensor, tracks per-slot stock and latches a sticky jam fault.
// Optional build macro JUICE_DISPENSE_STATS_EN adds a saturating 16-bit
// vend_count output counting successful juice vends.
module juice_dispense_ctrl #(
  parameter int PULSE_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STOCK_W        = 4,
  parameter int STOCK_INIT     = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  juice_dispense_ctrl_if.slave vend,
  output logic                 motor_1,
  output logic                 motor_2,
  output logic                 coin_return,
  input  logic                 drop_sensor,
  input  logic                 restock,
  output logic                 empty_1,
  output logic                 empty_2,
  output logic                 fault,
  input  logic                 fault_clr
`ifdef JUICE_DISPENSE_STATS_EN
  ,
  output logic [15:0]          vend_count
`endif
);

  localparam logic [1:0] RES_OK       = 2'b00;
  localparam logic [1:0] RES_REFUNDED = 2'b01;
  localparam logic [1:0] RES_TIMEOUT  = 2'b10;
  localparam logic [1:0] RES_ILLEGAL  = 2'b11;

  // One shared counter serves both the pulse timer and the drop timeout.
  localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STOCK_W-1:0] STOCK_LOAD   = STOCK_W'(STOCK_INIT);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT_DROP,
    RETURN,
    DONE
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [STOCK_W-1:0] stock_1_reg;
  logic [STOCK_W-1:0] stock_2_reg;
  logic               slot2_reg;     // 1: command targets slot 2
  logic               refund_reg;    // RETURN was entered because the slot was sold out
  logic               drop_latched_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [1:0]         result_reg;
  logic               fault_reg;
  logic               motor_1_reg;
  logic               motor_2_reg;
  logic               coin_return_reg;
  logic               sync_1_reg;
  logic               sync_2_reg;
  logic               sync_3_reg;
  logic               drop_evt;
  logic               accept;

`ifdef JUICE_DISPENSE_STATS_EN
  logic [15:0]        vend_count_reg;
  assign vend_count = vend_count_reg;
`endif

  // Ack is combinational so the requester sees it in the same cycle the
  // command is taken; restock in IDLE and a pending fault both block it.
  assign accept        = (state_reg == IDLE) && vend.vend_req && !fault_reg && !restock;
  assign vend.vend_ack = accept;
  assign vend.busy     = busy_reg;
  assign vend.done     = done_reg;
  assign vend.result   = result_reg;

  assign motor_1     = motor_1_reg;
  assign motor_2     = motor_2_reg;
  assign coin_return = coin_return_reg;
  assign fault       = fault_reg;
  assign empty_1     = (stock_1_reg == '0);
  assign empty_2     = (stock_2_reg == '0);

  // Rising edge of the synchronised sensor marks one product drop.
  assign drop_evt = sync_2_reg && !sync_3_reg;

  // Two-flop synchroniser plus edge-history flop for the asynchronous sensor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1_reg <= 1'b0;
      sync_2_reg <= 1'b0;
      sync_3_reg <= 1'b0;
    end else begin
      sync_1_reg <= drop_sensor;
      sync_2_reg <= sync_1_reg;
      sync_3_reg <= sync_2_reg;
    end
  end

  // Command FSM with registered actuator, status and stock state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      stock_1_reg      <= STOCK_LOAD;
      stock_2_reg      <= STOCK_LOAD;
      slot2_reg        <= 1'b0;
      refund_reg       <= 1'b0;
      drop_latched_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      result_reg       <= RES_OK;
      fault_reg        <= 1'b0;
      motor_1_reg      <= 1'b0;
      motor_2_reg      <= 1'b0;
      coin_return_reg  <= 1'b0;
`ifdef JUICE_DISPENSE_STATS_EN
      vend_count_reg   <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      // A timeout later in this block overrides the clear.
      if (fault_clr) fault_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (restock) begin
            stock_1_reg <= STOCK_LOAD;
            stock_2_reg <= STOCK_LOAD;
          end else if (accept) begin
            busy_reg         <= 1'b1;
            cnt_reg          <= '0;
            drop_latched_reg <= 1'b0;
            slot2_reg        <= vend.vend_sel[1];
            refund_reg       <= 1'b0;
            case (vend.vend_sel)
              2'b01: begin
                if (stock_1_reg != '0) begin
                  state_reg   <= DRIVE;
                  motor_1_reg <= 1'b1;
                end else begin
                  state_reg       <= RETURN;
                  coin_return_reg <= 1'b1;
                  refund_reg      <= 1'b1;
                end
              end
              2'b10: begin
                if (stock_2_reg != '0) begin
                  state_reg   <= DRIVE;
                  motor_2_reg <= 1'b1;
                end else begin
                  state_reg       <= RETURN;
                  coin_return_reg <= 1'b1;
                  refund_reg      <= 1'b1;
                end
              end
              2'b00: begin
                state_reg       <= RETURN;
                coin_return_reg <= 1'b1;
              end
              default: begin
                state_reg  <= DONE;
                done_reg   <= 1'b1;
                result_reg <= RES_ILLEGAL;
              end
            endcase
          end
        end

        DRIVE: begin
          if (drop_evt) drop_latched_reg <= 1'b1;
          if (cnt_reg == PULSE_LAST) begin
            motor_1_reg <= 1'b0;
            motor_2_reg <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= WAIT_DROP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        WAIT_DROP: begin
          if (drop_evt || drop_latched_reg) begin
            if (slot2_reg) begin
              if (stock_2_reg != '0) stock_2_reg <= stock_2_reg - STOCK_W'(1);
            end else begin
              if (stock_1_reg != '0) stock_1_reg <= stock_1_reg - STOCK_W'(1);
            end
`ifdef JUICE_DISPENSE_STATS_EN
            if (vend_count_reg != 16'hFFFF) vend_count_reg <= vend_count_reg + 16'd1;
`endif
            result_reg <= RES_OK;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            result_reg <= RES_TIMEOUT;
            fault_reg  <= 1'b1;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        RETURN: begin
          if (cnt_reg == PULSE_LAST) begin
            coin_return_reg <= 1'b0;
            result_reg      <= refund_reg ? RES_REFUNDED : RES_OK;
            done_reg        <= 1'b1;
            state_reg       <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
